// File: rtl/fxp_pkg.sv
// Shared fixed-point types and range helpers for the fxp_* blocks.
package fxp_pkg;

  typedef enum logic [1:0] {
    RND_TRUNC     = 2'd0,
    RND_HALF_UP   = 2'd1,
    RND_HALF_EVEN = 2'd2
  } rnd_mode_e;

  function automatic int fxp_imax(input int x, input int y);
    return (x > y) ? x : y;
  endfunction

  // Raw bounds, in units of the format's LSB.
  function automatic logic signed [63:0] fxp_max(input int int_b, input int frac_b, input bit sgn);
    if (sgn) return (64'sd1 <<< (int_b + frac_b - 1)) - 64'sd1;
    return (64'sd1 <<< (int_b + frac_b)) - 64'sd1;
  endfunction

  function automatic logic signed [63:0] fxp_min(input int int_b, input int frac_b, input bit sgn);
    if (sgn) return -(64'sd1 <<< (int_b + frac_b - 1));
    return 64'sd0;
  endfunction

endpackage

// File: rtl/fxp_round_sat.sv
// Combinational rounding + saturation of a two's-complement fixed-point value
// into a signed or unsigned output format.
module fxp_round_sat
  import fxp_pkg::*;
#(
  parameter int IN_INT   = 5,
  parameter int IN_FRAC  = 4,
  parameter int OUT_INT  = 3,
  parameter int OUT_FRAC = 1,
  parameter int SIGNED   = 0
) (
  input  logic signed [IN_INT+IN_FRAC-1:0]   din_i,
  input  logic [1:0]                         mode_i,
  output logic [OUT_INT+OUT_FRAC-1:0]        c_o,
  output logic                               ovf_o,
  output logic                               unf_o
);

  localparam int IN_W  = IN_INT + IN_FRAC;
  localparam int OUT_W = OUT_INT + OUT_FRAC;
  localparam logic signed [63:0] MAXV = fxp_max(OUT_INT, OUT_FRAC, SIGNED != 0);
  localparam logic signed [63:0] MINV = fxp_min(OUT_INT, OUT_FRAC, SIGNED != 0);

  logic signed [63:0] ext;
  logic signed [63:0] rnd;   // rounded value in output-LSB units

  assign ext = {{(64-IN_W){din_i[IN_W-1]}}, din_i};

  if (OUT_FRAC >= IN_FRAC) begin : g_shl
    always_comb rnd = ext <<< (OUT_FRAC - IN_FRAC);
  end else begin : g_rnd
    localparam int D = IN_FRAC - OUT_FRAC;
    logic signed [63:0] kept;
    logic [D-1:0]       drop, rest;
    logic               inc;
    always_comb begin
      kept    = ext >>> D;
      drop    = ext[D-1:0];
      rest    = drop;
      rest[D-1] = 1'b0;
      // A tie is MSB-of-dropped set with everything below it zero.
      case (mode_i)
        RND_HALF_UP:   inc = drop[D-1];
        RND_HALF_EVEN: inc = drop[D-1] & ((rest != '0) | kept[0]);
        default:       inc = 1'b0;
      endcase
      rnd = kept + {63'b0, inc};
    end
  end

  always_comb begin
    ovf_o = rnd > MAXV;
    unf_o = rnd < MINV;
    if (ovf_o)      c_o = MAXV[OUT_W-1:0];
    else if (unf_o) c_o = MINV[OUT_W-1:0];
    else            c_o = rnd[OUT_W-1:0];
  end

endmodule

// File: rtl/fxp_add_sat_pipe.sv
// Two-stage fixed-point add/sub with rounding, saturation, valid/ready
// flow control and a sticky saturation event counter.
module fxp_add_sat_pipe
  import fxp_pkg::*;
#(
  parameter int A_INT  = 3,
  parameter int A_FRAC = 4,
  parameter int B_INT  = 2,
  parameter int B_FRAC = 3,
  parameter int C_INT  = 3,
  parameter int C_FRAC = 1,
  parameter int SIGNED = 0,
  parameter int CNT_W  = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [A_INT+A_FRAC-1:0]  a,
  input  logic [B_INT+B_FRAC-1:0]  b,
  input  logic                     op,
  input  logic [1:0]               rnd_mode,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [C_INT+C_FRAC-1:0]  c,
  output logic                     ovf,
  output logic                     unf,
  input  logic                     cnt_clr,
  output logic [CNT_W-1:0]         sat_cnt
);

  localparam int A_W  = A_INT + A_FRAC;
  localparam int B_W  = B_INT + B_FRAC;
  localparam int C_W  = C_INT + C_FRAC;
  localparam int F    = fxp_imax(A_FRAC, B_FRAC);
  // Unsigned always gets the extra bit so a - b can go negative.
  localparam int I1   = fxp_imax(A_INT, B_INT) + ((SIGNED != 0) ? 1 : 2);
  localparam int S_W  = I1 + F;
  localparam bit SGN  = (SIGNED != 0);

  logic [S_W-1:0] a_ext, b_ext, a_al, b_al, sum_d, sum_q;
  logic [1:0]     mode_q;
  logic [2:1]     vld_q;
  logic           s1_ld, s2_ld;
  logic [C_W-1:0] c_q, rs_c;
  logic           ovf_q, unf_q, rs_ovf, rs_unf;
  logic [CNT_W-1:0] cnt_d, cnt_q;

  always_comb begin
    a_ext = {{(S_W-A_W){SGN & a[A_W-1]}}, a};
    b_ext = {{(S_W-B_W){SGN & b[B_W-1]}}, b};
    a_al  = a_ext << (F - A_FRAC);
    b_al  = b_ext << (F - B_FRAC);
    sum_d = op ? (a_al - b_al) : (a_al + b_al);
  end

  assign s2_ld    = ~vld_q[2] | out_ready;
  assign s1_ld    = ~vld_q[1] | s2_ld;
  assign in_ready = s1_ld;

  fxp_round_sat #(
    .IN_INT  (I1),
    .IN_FRAC (F),
    .OUT_INT (C_INT),
    .OUT_FRAC(C_FRAC),
    .SIGNED  (SIGNED)
  ) u_rs (
    .din_i (sum_q),
    .mode_i(mode_q),
    .c_o   (rs_c),
    .ovf_o (rs_ovf),
    .unf_o (rs_unf)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q  <= '0;
      sum_q  <= '0;
      mode_q <= '0;
      c_q    <= '0;
      ovf_q  <= 1'b0;
      unf_q  <= 1'b0;
    end else begin
      if (s1_ld) begin
        vld_q[1] <= in_valid;
        if (in_valid) begin
          sum_q  <= sum_d;
          mode_q <= rnd_mode;
        end
      end
      if (s2_ld) begin
        vld_q[2] <= vld_q[1];
        if (vld_q[1]) begin
          c_q   <= rs_c;
          ovf_q <= rs_ovf;
          unf_q <= rs_unf;
        end
      end
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clr)
      cnt_d = '0;
    else if (vld_q[2] & out_ready & (ovf_q | unf_q) & ~(&cnt_q))
      cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign out_valid = vld_q[2];
  assign c         = c_q;
  assign ovf       = ovf_q;
  assign unf       = unf_q;
  assign sat_cnt   = cnt_q;

endmodule

// File: tb/tb_fxp_add_sat_pipe.sv
// Directed-vector bench: default unsigned instance, a signed instance and a
// narrow-counter instance, all sharing one clock and reset.
module tb_fxp_add_sat_pipe;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // default instance
  logic iv0 = 0, ir0, op0 = 0, ov0, or0 = 1, ovf0, unf0, clr0 = 0;
  logic [6:0] a0 = 0;
  logic [4:0] b0 = 0;
  logic [1:0] m0 = 0;
  logic [3:0] c0;
  logic [15:0] cnt0;
  // signed: A 3.4, B 3.3, C 4.1
  logic iv1 = 0, ir1, op1 = 0, ov1, or1 = 1, ovf1, unf1, clr1 = 0;
  logic [6:0] a1 = 0;
  logic [5:0] b1 = 0;
  logic [1:0] m1 = 0;
  logic [4:0] c1;
  logic [15:0] cnt1;
  // 2-bit counter
  logic iv2 = 0, ir2, op2 = 0, ov2, or2 = 1, ovf2, unf2, clr2 = 0;
  logic [6:0] a2 = 0;
  logic [4:0] b2 = 0;
  logic [1:0] m2 = 0;
  logic [3:0] c2;
  logic [1:0] cnt2;

  fxp_add_sat_pipe dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv0), .in_ready(ir0), .a(a0), .b(b0),
    .op(op0), .rnd_mode(m0), .out_valid(ov0), .out_ready(or0), .c(c0),
    .ovf(ovf0), .unf(unf0), .cnt_clr(clr0), .sat_cnt(cnt0));

  fxp_add_sat_pipe #(.B_INT(3), .C_INT(4), .SIGNED(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1), .a(a1), .b(b1),
    .op(op1), .rnd_mode(m1), .out_valid(ov1), .out_ready(or1), .c(c1),
    .ovf(ovf1), .unf(unf1), .cnt_clr(clr1), .sat_cnt(cnt1));

  fxp_add_sat_pipe #(.CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv2), .in_ready(ir2), .a(a2), .b(b2),
    .op(op2), .rnd_mode(m2), .out_valid(ov2), .out_ready(or2), .c(c2),
    .ovf(ovf2), .unf(unf2), .cnt_clr(clr2), .sat_cnt(cnt2));

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // One transaction through dut0; returns the presented result after it transfers.
  task automatic xfer0(input logic [6:0] ta, input logic [4:0] tb, input logic top,
                       input logic [1:0] tm, output logic [3:0] rc, output logic rovf,
                       output logic runf);
    int k;
    a0 = ta; b0 = tb; op0 = top; m0 = tm; iv0 = 1; or0 = 1;
    cyc();
    iv0 = 0;
    k = 0;
    while (ov0 !== 1'b1 && k < 20) begin cyc(); k++; end
    n_cmp++;
    if (k >= 20) begin n_bad++; $display("FAIL xfer0_timeout: no out_valid within 20 cycles"); end
    rc = c0; rovf = ovf0; runf = unf0;
    cyc();
  endtask

  task automatic xfer1(input logic [6:0] ta, input logic [5:0] tb, input logic top,
                       input logic [1:0] tm, output logic [4:0] rc, output logic rovf,
                       output logic runf);
    int k;
    a1 = ta; b1 = tb; op1 = top; m1 = tm; iv1 = 1; or1 = 1;
    cyc();
    iv1 = 0;
    k = 0;
    while (ov1 !== 1'b1 && k < 20) begin cyc(); k++; end
    n_cmp++;
    if (k >= 20) begin n_bad++; $display("FAIL xfer1_timeout: no out_valid within 20 cycles"); end
    rc = c1; rovf = ovf1; runf = unf1;
    cyc();
  endtask

  task automatic test_reset();
    cyc(); cyc();
    n_cmp++;
    if ({ov0, c0, ovf0, unf0, cnt0} !== 23'd0) begin
      n_bad++; $display("FAIL reset_outputs: got ov=%b c=%h ovf=%b unf=%b cnt=%0d, want all 0", ov0, c0, ovf0, unf0, cnt0);
    end
    n_cmp++;
    if ({ir0, ir1, ir2} !== 3'b111) begin
      n_bad++; $display("FAIL reset_in_ready: got %b, want 111", {ir0, ir1, ir2});
    end
    rst_n = 1'b1;
    cyc();
  endtask

  task automatic test_basic();
    a0 = 7'h10; b0 = 5'h04; op0 = 0; m0 = 0; iv0 = 1; or0 = 1;
    cyc();
    iv0 = 0;
    n_cmp++;
    if (ov0 !== 1'b0) begin n_bad++; $display("FAIL basic_lat1: out_valid=%b one cycle after accept, want 0", ov0); end
    cyc();
    n_cmp++;
    if (ov0 !== 1'b1 || c0 !== 4'h3 || ovf0 !== 1'b0 || unf0 !== 1'b0) begin
      n_bad++; $display("FAIL basic_result: got ov=%b c=%h ovf=%b unf=%b, want 1 3 0 0", ov0, c0, ovf0, unf0);
    end
    cyc();
    n_cmp++;
    if (ov0 !== 1'b0) begin n_bad++; $display("FAIL basic_drain: out_valid=%b after transfer, want 0", ov0); end
  endtask

  task automatic test_ovf();
    logic [3:0] rc; logic rovf, runf;
    xfer0(7'h7F, 5'h1F, 1'b0, 2'd0, rc, rovf, runf);
    n_cmp++;
    if (rc !== 4'hF || rovf !== 1'b1 || runf !== 1'b0) begin
      n_bad++; $display("FAIL ovf_result: got c=%h ovf=%b unf=%b, want F 1 0", rc, rovf, runf);
    end
    n_cmp++;
    if (cnt0 !== 16'd1) begin n_bad++; $display("FAIL ovf_cnt: got %0d, want 1", cnt0); end
  endtask

  logic [6:0] rt_a   [8] = '{7'h14, 7'h14, 7'h14, 7'h1C, 7'h1C, 7'h1C, 7'h7F, 7'h7F};
  logic [1:0] rt_m   [8] = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd2, 2'd3, 2'd0, 2'd1};
  logic [3:0] rt_c   [8] = '{4'h2, 4'h3, 4'h2, 4'h3, 4'h4, 4'h3, 4'hF, 4'hF};
  logic       rt_ovf [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

  task automatic test_round();
    logic [3:0] rc; logic rovf, runf;
    for (int i = 0; i < 8; i++) begin
      xfer0(rt_a[i], 5'h00, 1'b0, rt_m[i], rc, rovf, runf);
      n_cmp++;
      if (rc !== rt_c[i] || rovf !== rt_ovf[i] || runf !== 1'b0) begin
        n_bad++; $display("FAIL round_%0d: got c=%h ovf=%b unf=%b, want %h %b 0", i, rc, rovf, runf, rt_c[i], rt_ovf[i]);
      end
    end
  endtask

  task automatic test_sub();
    logic [3:0] rc; logic rovf, runf;
    xfer0(7'h10, 5'h10, 1'b1, 2'd0, rc, rovf, runf);
    n_cmp++;
    if (rc !== 4'h0 || rovf !== 1'b0 || runf !== 1'b1) begin
      n_bad++; $display("FAIL sub_unf: got c=%h ovf=%b unf=%b, want 0 0 1", rc, rovf, runf);
    end
    n_cmp++;
    if (cnt0 !== 16'd3) begin n_bad++; $display("FAIL sub_cnt: got %0d, want 3", cnt0); end
  endtask

  logic [6:0] sg_a  [4] = '{7'h10, 7'h3F, 7'h3F, 7'h40};
  logic [5:0] sg_b  [4] = '{6'h10, 6'h1F, 6'h1F, 6'h1F};
  logic       sg_op [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
  logic [1:0] sg_m  [4] = '{2'd0, 2'd0, 2'd1, 2'd0};
  logic [4:0] sg_c  [4] = '{5'h1E, 5'h0F, 5'h0F, 5'h10};
  logic       sg_ov [4] = '{1'b0, 1'b0, 1'b1, 1'b0};

  task automatic test_signed();
    logic [4:0] rc; logic rovf, runf;
    for (int i = 0; i < 4; i++) begin
      xfer1(sg_a[i], sg_b[i], sg_op[i], sg_m[i], rc, rovf, runf);
      n_cmp++;
      if (rc !== sg_c[i] || rovf !== sg_ov[i] || runf !== 1'b0) begin
        n_bad++; $display("FAIL signed_%0d: got c=%h ovf=%b unf=%b, want %h %b 0", i, rc, rovf, runf, sg_c[i], sg_ov[i]);
      end
    end
    n_cmp++;
    if (cnt1 !== 16'd1) begin n_bad++; $display("FAIL signed_cnt: got %0d, want 1", cnt1); end
  endtask

  task automatic test_backpressure();
    int sent = 0, got = 0, k = 0;
    logic acc, hv = 1'b0;
    logic [3:0] held = '0;
    logic [3:0] res [4];
    for (int i = 0; i < 6; i++) begin
      or0 = 0;
      iv0 = (sent < 4); a0 = 7'(8 * (sent + 1)); b0 = 0; op0 = 0; m0 = 0;
      #1;
      acc = iv0 & ir0;
      if (hv) begin
        n_cmp++;
        if (c0 !== held || ovf0 !== 1'b0 || c0 !== 4'h1) begin
          n_bad++; $display("FAIL bp_hold: c=%h ovf=%b during stall, want 1 0", c0, ovf0);
        end
      end
      if (ov0) begin held = c0; hv = 1'b1; end
      cyc();
      if (acc) sent++;
    end
    n_cmp++;
    if (sent !== 2 || ir0 !== 1'b0 || ov0 !== 1'b1) begin
      n_bad++; $display("FAIL bp_full: accepted=%0d in_ready=%b out_valid=%b, want 2 0 1", sent, ir0, ov0);
    end
    while ((got < 4 || sent < 4) && k < 30) begin
      or0 = 1;
      iv0 = (sent < 4); a0 = 7'(8 * (sent + 1));
      #1;
      acc = iv0 & ir0;
      if (ov0) begin
        if (got < 4) res[got] = c0;
        got++;
      end
      cyc();
      if (acc) sent++;
      k++;
    end
    iv0 = 0;
    n_cmp++;
    if (got !== 4) begin n_bad++; $display("FAIL bp_count: got %0d results, want 4", got); end
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (res[i] !== 4'(i + 1)) begin
        n_bad++; $display("FAIL bp_order_%0d: got c=%h, want %h", i, res[i], 4'(i + 1));
      end
    end
  endtask

  task automatic test_cnt_narrow();
    int nv = 0, k;
    or2 = 1; a2 = 7'h7F; b2 = 5'h1F; op2 = 0; m2 = 0;
    for (int i = 0; i < 12; i++) begin
      iv2 = (i < 5);
      if (ov2) begin
        nv++;
        n_cmp++;
        if (c2 !== 4'hF || ovf2 !== 1'b1 || unf2 !== 1'b0) begin
          n_bad++; $display("FAIL cnt_data: got c=%h ovf=%b unf=%b, want F 1 0", c2, ovf2, unf2);
        end
      end
      cyc();
    end
    n_cmp++;
    if (nv !== 5) begin n_bad++; $display("FAIL cnt_thru: got %0d output cycles, want 5", nv); end
    n_cmp++;
    if (cnt2 !== 2'd3) begin n_bad++; $display("FAIL cnt_stick: got %0d, want 3", cnt2); end
    clr2 = 1; cyc(); clr2 = 0;
    n_cmp++;
    if (cnt2 !== 2'd0) begin n_bad++; $display("FAIL cnt_clr: got %0d, want 0", cnt2); end
    // one saturating transfer, then a second one coinciding with cnt_clr
    for (int j = 0; j < 2; j++) begin
      iv2 = 1; cyc(); iv2 = 0;
      k = 0;
      while (ov2 !== 1'b1 && k < 20) begin cyc(); k++; end
      if (k >= 20) begin n_cmp++; n_bad++; $display("FAIL cnt_timeout: no out_valid within 20 cycles"); end
      clr2 = (j == 1);
      cyc();
      clr2 = 0;
      n_cmp++;
      if (cnt2 !== 2'(1 - j)) begin
        n_bad++; $display("FAIL cnt_clr_prio_%0d: got %0d, want %0d", j, cnt2, 1 - j);
      end
    end
  endtask

  task automatic test_reset_midflight();
    int stale = 0;
    or0 = 0; op0 = 0; m0 = 0; b0 = 0;
    a0 = 7'h10; iv0 = 1; cyc();
    a0 = 7'h18; cyc();
    iv0 = 0;
    n_cmp++;
    if (ov0 !== 1'b1 || ir0 !== 1'b0) begin
      n_bad++; $display("FAIL rst_pre: out_valid=%b in_ready=%b, want 1 0", ov0, ir0);
    end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({ov0, c0, ovf0, unf0, cnt0} !== 23'd0 || ir0 !== 1'b1) begin
      n_bad++; $display("FAIL rst_async: ov=%b c=%h ovf=%b unf=%b cnt=%0d ir=%b, want 0s and ir 1", ov0, c0, ovf0, unf0, cnt0, ir0);
    end
    cyc();
    rst_n = 1'b1;
    or0 = 1;
    for (int i = 0; i < 5; i++) begin
      if (ov0) stale++;
      cyc();
    end
    n_cmp++;
    if (stale !== 0) begin n_bad++; $display("FAIL rst_stale: %0d stale output cycles, want 0", stale); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_ovf();
    test_round();
    test_sub();
    test_signed();
    test_backpressure();
    test_cnt_narrow();
    test_reset_midflight();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
